ahb_bram_ctrl: RTL

//  AHB-Lite slave that drives the two-port word RAM, which has one write port and one read port.

---
 rtl/ahb_pkg.sv | 22 ++
 rtl/ahb_bram_lane_decode.sv | 42 ++++
 rtl/ahb_bram_ctrl.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/ahb_pkg.sv
// ahb_pkg
//   Shared encodings for the AHB-Lite block RAM controller: transfer types,
//   transfer sizes, response codes and error-FSM state encodings.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  localparam logic [1:0] ST_OK   = 2'd0;
  localparam logic [1:0] ST_ERR1 = 2'd1;
  localparam logic [1:0] ST_ERR2 = 2'd2;

endpackage

// File: rtl/ahb_bram_lane_decode.sv
// ahb_bram_lane_decode
//   Combinational byte-lane decoder. Turns the transfer size and the low two
//   address bits into a 4-bit byte-lane mask, and flags whether the size is
//   supported and the address is naturally aligned for that size.
// Ports
//   hsize    in   3   transfer size
//   addr_lo  in   2   haddr[1:0]
//   mask     out  4   byte-lane enables (bit i = byte i of the word)
//   legal    out  1   size supported and address aligned
module ahb_bram_lane_decode
  import ahb_pkg::*;
(
  input  logic [2:0] hsize,
  input  logic [1:0] addr_lo,
  output logic [3:0] mask,
  output logic       legal
);

  always_comb begin
    mask  = 4'b0000;
    legal = 1'b0;
    case (hsize)
      HSIZE_BYTE: begin
        mask  = 4'b0001 << addr_lo;
        legal = 1'b1;
      end
      HSIZE_HALF: begin
        mask  = addr_lo[1] ? 4'b1100 : 4'b0011;
        legal = ~addr_lo[0];
      end
      HSIZE_WORD: begin
        mask  = 4'b1111;
        legal = (addr_lo == 2'b00);
      end
      default: begin
        mask  = 4'b0000;
        legal = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/ahb_bram_ctrl.sv
// ahb_bram_ctrl
//   AHB-Lite slave in front of a two-port word RAM (one write port, one
//   registered read port). Legal accesses complete with zero wait states;
//   a read that immediately follows a write to the same word gets the freshly
//   written bytes forwarded. Illegal accesses get the two-cycle ERROR response.
// Ports
//   clka, rst                  clock, asynchronous active-high reset
//   hsel, haddr, htrans,       AHB-Lite address phase
//   hsize, hwrite, hready
//   hwdata                     AHB-Lite write data (data phase)
//   hreadyout, hresp, hrdata   AHB-Lite slave response
//   ram_addra/dina/wea         RAM write port (byte enables)
//   ram_addrb, ram_doutb       RAM read port (data one cycle after address)
//
// Error FSM
//   state   | meaning
//   ST_OK   | normal operation, OKAY response
//   ST_ERR1 | first ERROR cycle, hreadyout low
//   ST_ERR2 | second ERROR cycle, hreadyout high
module ahb_bram_ctrl
  import ahb_pkg::*;
#(
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clka,
  input  logic                  rst,
  input  logic                  hsel,
  input  logic [31:0]           haddr,
  input  logic [1:0]            htrans,
  input  logic [2:0]            hsize,
  input  logic                  hwrite,
  input  logic                  hready,
  input  logic [31:0]           hwdata,
  output logic                  hreadyout,
  output logic                  hresp,
  output logic [31:0]           hrdata,
  output logic [ADDR_WIDTH-1:0] ram_addra,
  output logic [31:0]           ram_dina,
  output logic [3:0]            ram_wea,
  output logic [ADDR_WIDTH-1:0] ram_addrb,
  input  logic [31:0]           ram_doutb
);

  logic                  trans_active;
  logic                  acc;
  logic                  acc_ok;
  logic                  acc_bad;
  logic [3:0]            lane_mask;
  logic                  lane_legal;
  logic                  in_range;
  logic [ADDR_WIDTH-1:0] word_addr;

  logic [1:0]            st;
  logic                  wr_pend;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [3:0]            wr_mask;
  logic                  fwd_hit;
  logic [3:0]            fwd_mask;
  logic [31:0]           fwd_data;

  always_comb begin
    trans_active = 1'b0;
    case (htrans)
      HTRANS_IDLE, HTRANS_BUSY: trans_active = 1'b0;
      HTRANS_NONSEQ, HTRANS_SEQ: trans_active = 1'b1;
      default: trans_active = 1'b0;
    endcase
  end

  ahb_bram_lane_decode u_lane_decode (
    .hsize   (hsize),
    .addr_lo (haddr[1:0]),
    .mask    (lane_mask),
    .legal   (lane_legal)
  );

  assign word_addr = haddr[ADDR_WIDTH+1:2];
  assign in_range  = (haddr[31:ADDR_WIDTH+2] == '0);
  assign acc       = hsel & trans_active & hready;
  assign acc_ok    = acc & lane_legal & in_range;
  assign acc_bad   = acc & ~(lane_legal & in_range);

  // Write and forwarding state only advances when the bus completes a beat.
  // While a wait state holds hready low the same write is simply repeated
  // with stable hwdata, which is harmless.
  always_ff @(posedge clka or posedge rst) begin
    if (rst) begin
      wr_pend  <= 1'b0;
      wr_addr  <= '0;
      wr_mask  <= 4'b0000;
      fwd_hit  <= 1'b0;
      fwd_mask <= 4'b0000;
      fwd_data <= 32'h0;
    end else if (hready) begin
      wr_pend <= acc_ok & hwrite;
      if (acc_ok & hwrite) begin
        wr_addr <= word_addr;
        wr_mask <= lane_mask;
      end
      // The RAM read issued now samples the word before the in-flight write
      // commits, so capture the bytes being written to patch the read data.
      fwd_hit <= acc_ok & ~hwrite & wr_pend & (wr_addr == word_addr);
      if (acc_ok & ~hwrite & wr_pend & (wr_addr == word_addr)) begin
        fwd_mask <= wr_mask;
        fwd_data <= hwdata;
      end
    end
  end

  always_ff @(posedge clka or posedge rst) begin
    if (rst) begin
      st <= ST_OK;
    end else begin
      case (st)
        ST_OK:   st <= acc_bad ? ST_ERR1 : ST_OK;
        ST_ERR1: st <= ST_ERR2;
        ST_ERR2: st <= acc_bad ? ST_ERR1 : ST_OK;
        default: st <= ST_OK;
      endcase
    end
  end

  assign hreadyout = (st != ST_ERR1);
  assign hresp     = (st == ST_OK) ? HRESP_OKAY : HRESP_ERROR;

  assign ram_addra = wr_addr;
  assign ram_dina  = hwdata;
  assign ram_wea   = wr_pend ? wr_mask : 4'b0000;
  assign ram_addrb = word_addr;

  always_comb begin
    hrdata = ram_doutb;
    for (int i = 0; i < 4; i++) begin
      if (fwd_hit & fwd_mask[i]) begin
        hrdata[8*i +: 8] = fwd_data[8*i +: 8];
      end
    end
  end

endmodule
